// File: rtl/gray2bin_pipe_pkg.sv
// Shared Gray-code types, constants and reference conversions for the gray2bin_pipe slice.
package gray_pkg;

  localparam int unsigned GRAY_PIPE_LAT = 2;
  localparam int unsigned GRAY_WIDTH    = 4;
  localparam int unsigned GRAY_MAX_W    = 32;

  typedef logic [GRAY_WIDTH-1:0] gray_word_t;
  typedef logic [GRAY_MAX_W-1:0] gray_max_t;

  // Width-generic wrappers: operate on a GRAY_MAX_W container, only the low w bits are meaningful.
  function automatic gray_max_t gray_mask(input int unsigned w);
    gray_max_t m;
    m = '0;
    for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic gray_max_t gray2bin(input gray_max_t g, input int unsigned w);
    gray_max_t b;
    b = g & gray_mask(w);
    for (int unsigned s = 1; s < GRAY_MAX_W; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

  function automatic gray_max_t bin2gray(input gray_max_t b, input int unsigned w);
    gray_max_t m;
    m = b & gray_mask(w);
    return m ^ (m >> 1);
  endfunction

endpackage

// File: rtl/gray2bin_pipe_if.sv
// Valid/ready stream bundle for the Gray-to-binary pipeline: Gray words in, binary words out.
interface gray2bin_pipe_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic [WIDTH-1:0] gray_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] bin_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output gray_in, in_valid, out_ready,
    input  in_ready, bin_out, out_valid
  );

  modport slave (
    input  gray_in, in_valid, out_ready,
    output in_ready, bin_out, out_valid
  );

endinterface

// File: rtl/gray2bin_pipe_comb.sv
// Purely combinational WIDTH-bit Gray-to-binary decoder (running XOR from the MSB down).
module gray2bin_comb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic acc;

  always_comb begin
    acc = 1'b0;
    bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      acc                = acc ^ gray[WIDTH-1-i];
      bin[WIDTH-1-i]     = acc;
    end
  end

endmodule

// File: rtl/gray2bin_pipe.sv
// Two-stage streaming Gray-to-binary decoder with full backpressure.
// Optional single-bit-step checker enabled by defining GRAY_STEP_CHECK_EN.
module gray2bin_pipe
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  gray2bin_pipe_if.slave    bus,
  input  logic              err_clr,
  output logic              step_err
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic [WIDTH-1:0] s1_decoded;
  logic             s2_accept;
  logic             s1_accept;
  logic             in_fire;

  // Ready ripples back combinationally so a draining output frees both stages in one cycle.
  assign s2_accept = !s2_valid || bus.out_ready;
  assign s1_accept = !s1_valid || s2_accept;
  assign in_fire   = bus.in_valid && s1_accept;

  assign bus.in_ready  = s1_accept;
  assign bus.out_valid = s2_valid;
  assign bus.bin_out   = s2_data;

  gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
    .gray (s1_data),
    .bin  (s1_decoded)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (s1_accept) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) s1_data <= bus.gray_in;
      end
      if (s2_accept) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_decoded;
      end
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             prev_valid;
  logic [WIDTH-1:0] prev_word;
  logic [WIDTH-1:0] diff;
  logic             step_viol;

  // diff & (diff-1) is non-zero exactly when two or more bits changed.
  always_comb begin
    diff      = prev_word ^ bus.gray_in;
    step_viol = in_fire && prev_valid && ((diff & (diff - ONE)) != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
      prev_word  <= '0;
      step_err   <= 1'b0;
    end else begin
      if (in_fire) begin
        prev_valid <= 1'b1;
        prev_word  <= bus.gray_in;
      end
      if (step_viol)    step_err <= 1'b1;
      else if (err_clr) step_err <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign step_err       = 1'b0;
`endif

endmodule

// File: tb/tb_gray2bin_pipe.sv
// Scoreboard bench for gray2bin_pipe: directed Gray vectors with hand-computed binary results.
module tb_gray2bin_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic step_err;

  gray2bin_pipe_if #(.WIDTH(4)) bus ();

  gray2bin_pipe #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .err_clr  (err_clr),
    .step_err (step_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] exp;
    int         cyc;
    bit         lat;
  } item_t;

  item_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  task automatic set_ready(input int m);
    ready_mode = m;
    case (m)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  endtask

  // Monitor: handshake-level checks and scoreboard pops, sampled on the falling edge.
  initial begin
    int         occ;
    bit         stall_prev;
    logic [3:0] stall_val;
    item_t      it;
    occ = 0;
    stall_prev = 1'b0;
    stall_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        occ = 0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", int'(bus.out_valid), 1);
          chk("hold_data", int'(bus.bin_out), int'(stall_val));
        end
        chk("in_ready", int'(bus.in_ready), int'(!(occ == 2 && !bus.out_ready)));
        if (bus.in_valid && bus.in_ready) occ++;
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", int'(bus.bin_out), -1);
          end else begin
            it = sb.pop_front();
            chk("data", int'(bus.bin_out), int'(it.exp));
            if (it.lat) chk("latency", cyc - it.cyc, 2);
          end
          occ--;
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        stall_val  = bus.bin_out;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] g, input logic [3:0] exp, input bit lat, output int waited);
    bit done;
    bus.gray_in  = g;
    bus.in_valid = 1'b1;
    waited = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back('{exp: exp, cyc: cyc, lat: lat});
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 60) begin
          chk("send_timeout", waited, 0);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_bin_out", int'(bus.bin_out), 0);
    chk("rst_step_err", int'(step_err), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
  endtask

  task automatic drain();
    set_ready(0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  logic [3:0] t2_g [5]  = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
  logic [3:0] all_g [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  initial begin
    int w;
    bus.gray_in   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // 1: single word, latency 2
    send(4'b0110, 4'b0100, 1'b1, w);
    drain();

    // 2: back-to-back, no backpressure
    for (int i = 0; i < 5; i++) begin
      send(t2_g[i], 4'(i), 1'b1, w);
      chk("t2_no_wait", w, 0);
    end
    drain();

    // 3: all 16 codes under random backpressure
    set_ready(1);
    for (int i = 0; i < 16; i++) begin
      send(all_g[i], 4'(i), 1'b0, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    // 4: fill both stages, stall five cycles with a third word waiting
    set_ready(2);
    send(4'b1000, 4'b1111, 1'b0, w);
    send(4'b1111, 4'b1010, 1'b0, w);
    bus.gray_in  = 4'b1110;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready", int'(bus.in_ready), 0);
    end
    chk("t4_out_valid", int'(bus.out_valid), 1);
    chk("t4_head", int'(bus.bin_out), 4'b1111);
    @(posedge clk);
    #1;
    set_ready(0);
    send(4'b1110, 4'b1011, 1'b0, w);
    chk("t4_release_wait", w, 0);
    drain();

`ifdef GRAY_STEP_CHECK_EN
    // 5: step checker
    do_reset();
    send(4'b1111, 4'b1010, 1'b0, w);
    chk("t5_first_word", int'(step_err), 0);
    drain();
    do_reset();
    send(4'b0000, 4'b0000, 1'b0, w);
    chk("t5_after_0000", int'(step_err), 0);
    send(4'b0011, 4'b0010, 1'b0, w);
    chk("t5_violation", int'(step_err), 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("t5_cleared", int'(step_err), 0);
    err_clr = 1'b1;
    send(4'b0000, 4'b0000, 1'b0, w);
    err_clr = 1'b0;
    chk("t5_set_wins", int'(step_err), 1);
    drain();
`else
    do_reset();
    send(4'b0000, 4'b0000, 1'b0, w);
    send(4'b0011, 4'b0010, 1'b0, w);
    chk("t5_tied_off", int'(step_err), 0);
    drain();
`endif

    // 6: reset with both stages full, then normal operation
    set_ready(2);
    send(4'b0001, 4'b0001, 1'b0, w);
    send(4'b0010, 4'b0011, 1'b0, w);
    chk("t6_full", int'(bus.in_ready), 0);
    do_reset();
    set_ready(0);
    send(4'b0101, 4'b0110, 1'b1, w);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
